imem_ldr: RTL and testbench

Instruction-memory program loader: the write-side counterpart of the processor's instruction fetch path. Receives a framed byte stream (length, big-endian 16-bit instruction words, XOR checksum) over a valid/ready handshake, writes each word into instruction memory at consecutive addresses from 0, and holds the processor in reset until a load completes with a correct checksum. Sits between the external download port and the processor's `imem` write port and reset input.

---
 rtl/imem_ldr_pkg.sv | 22 ++
 rtl/imem_ldr.sv | 160 ++++++++++++++++
 tb/tb_imem_ldr.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_ldr_pkg.sv
// imem_ldr_pkg
// Shared definitions for the instruction-memory program loader:
//   - loader FSM state encoding
//   - default address / data widths
//   - word count implied by a LEN byte of zero
package imem_ldr_pkg;

    localparam int AW_DEF         = 6;
    localparam int DW_DEF         = 16;
    localparam int LEN_ZERO_WORDS = 64;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        HI,
        LO,
        SUM,
        RUN,
        ERR
    } state_e;

endpackage

// File: rtl/imem_ldr.sv
// imem_ldr
// Instruction-memory program loader. Consumes a framed byte stream
// (LEN, N big-endian 16-bit words, XOR checksum), writes the words to
// instruction memory from address 0 and keeps the processor in reset until
// a frame finishes with a matching checksum.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   start     one-cycle pulse, begins a (re)load from IDLE/RUN/ERR
//   in_valid  byte present on in_data
//   in_data   stream byte
//   in_ready  loader accepts in_data this cycle (state-only decode)
//   imem_we   instruction-memory write strobe
//   imem_wa   write address
//   imem_wd   write data
//   cpu_hold  1 = processor held in reset
//   done      last load completed with good checksum
//   err       last load completed with bad checksum
//
// state | meaning
// IDLE  | after reset, waiting for start
// LEN   | expecting the length byte
// HI    | expecting high byte of next word
// LO    | expecting low byte; word written on transfer
// SUM   | expecting checksum byte
// RUN   | program loaded, processor released
// ERR   | checksum mismatch, processor held
module imem_ldr
    import imem_ldr_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_wa,
    output logic [DW-1:0] imem_wd,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);

    // Word counter is one bit wider than the address so a full 64-word
    // frame can be represented.
    localparam int CW = AW + 1;

    state_e        r_state;
    state_e        w_next;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_sum;
    logic [7:0]    r_hi;
    logic          r_we;
    logic [AW-1:0] r_wa;
    logic [DW-1:0] r_wd;
    logic          r_done;
    logic          r_err;

    logic          w_ready;
    logic          w_xfer;
    logic          w_last;

    assign w_xfer = in_valid & w_ready;
    assign w_last = ({1'b0, r_addr} == (r_cnt - CW'(1)));

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            IDLE: if (start) w_next = LEN;
            LEN: begin
                w_ready = 1'b1;
                if (in_valid) w_next = HI;
            end
            HI: begin
                w_ready = 1'b1;
                if (in_valid) w_next = LO;
            end
            LO: begin
                w_ready = 1'b1;
                if (in_valid) w_next = w_last ? SUM : HI;
            end
            SUM: begin
                w_ready = 1'b1;
                if (in_valid) w_next = (in_data == r_sum) ? RUN : ERR;
            end
            RUN:     if (start) w_next = LEN;
            ERR:     if (start) w_next = LEN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_addr <= '0;
            r_sum  <= '0;
            r_hi   <= '0;
            r_we   <= 1'b0;
            r_wa   <= '0;
            r_wd   <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_xfer) begin
                case (r_state)
                    LEN: begin
                        r_cnt  <= (in_data == 8'd0) ? CW'(LEN_ZERO_WORDS) : CW'(in_data);
                        r_addr <= '0;
                        r_sum  <= '0;
                        r_done <= 1'b0;
                        r_err  <= 1'b0;
                    end
                    HI: begin
                        r_hi  <= in_data;
                        r_sum <= r_sum ^ in_data;
                    end
                    LO: begin
                        r_wa   <= r_addr;
                        r_wd   <= DW'({r_hi, in_data});
                        r_we   <= 1'b1;
                        r_sum  <= r_sum ^ in_data;
                        r_addr <= r_addr + AW'(1);
                    end
                    SUM: begin
                        r_done <= (in_data == r_sum);
                        r_err  <= (in_data != r_sum);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Hold follows the state register directly: it drops on entry to RUN
    // and rises again the cycle a restart moves the FSM into LEN.
    assign in_ready = w_ready;
    assign imem_we  = r_we;
    assign imem_wa  = r_wa;
    assign imem_wd  = r_wd;
    assign cpu_hold = (r_state != RUN);
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_imem_ldr.sv
// tb_imem_ldr
// Self-checking bench for imem_ldr: builds frames, predicts every memory
// write (address, data, cycle) and the done/err/cpu_hold outcome from the
// frame contents, and checks the DUT against those predictions.
module tb_imem_ldr;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        imem_we;
    logic [5:0]  imem_wa;
    logic [15:0] imem_wd;
    logic        cpu_hold;
    logic        done;
    logic        err;

    imem_ldr dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .imem_we  (imem_we),
        .imem_wa  (imem_wa),
        .imem_wd  (imem_wd),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int a;
        int d;
        int c;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] fr[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    // Every write strobe must match the oldest predicted write, including
    // the cycle it was predicted for.
    always @(negedge clk) begin
        if (rst && imem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(imem_wa), 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("write_addr", 32'(imem_wa), 32'(w.a));
                check("write_data", 32'(imem_wd), 32'(w.d));
                check("write_cycle", 32'(cyc), 32'(w.c));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok;
        bit rdy;
        int g;
        g = 0;
        while (gaps && ($urandom_range(0, 1) == 1) && g < 8) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            g++;
        end
        in_valid = 1'b1;
        in_data  = b;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) check("xfer_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [7:0] xor_of_frame();
        logic [7:0] x;
        x = 8'h00;
        foreach (fr[i]) x = x ^ fr[i];
        return x;
    endfunction

    // Sends LEN, the data bytes in fr, and the given checksum; predicts the
    // writes and the final status from the frame alone.
    task automatic send_frame(input int n, input logic [7:0] sum, input bit gaps);
        bit good;
        good = (sum == xor_of_frame());
        send_byte((n == 64) ? 8'h00 : 8'(n), gaps);
        for (int i = 0; i < n; i++) begin
            wr_t w;
            send_byte(fr[2*i], gaps);
            send_byte(fr[2*i+1], gaps);
            w.a = i;
            w.d = int'({fr[2*i], fr[2*i+1]});
            w.c = cyc;
            exp_q.push_back(w);
        end
        send_byte(sum, gaps);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        check("done", 32'(done), 32'(good));
        check("err", 32'(err), 32'(!good));
        check("cpu_hold", 32'(cpu_hold), 32'(!good));
        check("ready_after_sum", 32'(in_ready), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_we"}, 32'(imem_we), 32'd0);
        check({tag, "_wa"}, 32'(imem_wa), 32'd0);
        check({tag, "_wd"}, 32'(imem_wd), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] s;
        #12;
        check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // IDLE ignores in_valid
        in_valid = 1'b1;
        in_data  = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("idle_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        check("idle_hold", 32'(cpu_hold), 32'd1);

        // three-word frame at full rate, correct checksum
        pulse_start();
        fr = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        send_frame(3, xor_of_frame(), 1'b0);

        // RUN ignores in_valid; start reasserts hold next cycle
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("run_ready", 32'(in_ready), 32'd0);
            check("run_done", 32'(done), 32'd1);
        end
        in_valid = 1'b0;
        pulse_start();
        check("restart_hold", 32'(cpu_hold), 32'd1);
        check("restart_ready", 32'(in_ready), 32'd1);

        // same frame, bad checksum, then a good reload
        send_frame(3, 8'h00, 1'b0);
        pulse_start();
        send_frame(3, xor_of_frame(), 1'b0);

        // LEN=0 means 64 words
        pulse_start();
        fr = {};
        for (int k = 0; k < 128; k++) fr.push_back(8'(k));
        send_frame(64, xor_of_frame(), 1'b0);

        // randomly gapped in_valid
        pulse_start();
        fr = '{8'hAB, 8'hCD};
        send_frame(1, 8'h66, 1'b1);

        // start pulses inside a frame are ignored
        pulse_start();
        fr = '{8'h11, 8'h22, 8'h33, 8'h44};
        s = xor_of_frame();
        send_byte(8'h02, 1'b0);
        pulse_start();
        send_byte(fr[0], 1'b0);
        pulse_start();
        send_byte(fr[1], 1'b0);
        begin
            wr_t w;
            w.a = 0; w.d = 16'h1122; w.c = cyc;
            exp_q.push_back(w);
        end
        send_byte(fr[2], 1'b0);
        send_byte(fr[3], 1'b0);
        begin
            wr_t w;
            w.a = 1; w.d = 16'h3344; w.c = cyc;
            exp_q.push_back(w);
        end
        pulse_start();
        send_byte(s, 1'b0);
        check("midstart_done", 32'(done), 32'd1);
        check("midstart_pending", 32'(exp_q.size()), 32'd0);

        // reset while waiting for a LO byte of a 4-word frame
        pulse_start();
        send_byte(8'h04, 1'b0);
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        begin
            wr_t w;
            w.a = 0; w.d = 16'hDEAD; w.c = cyc;
            exp_q.push_back(w);
        end
        send_byte(8'hBE, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_pending", 32'(exp_q.size()), 32'd0);
        check("midreset_ready", 32'(in_ready), 32'd0);
        pulse_start();
        fr = '{8'hC3, 8'h5E};
        send_frame(1, xor_of_frame(), 1'b0);

        // random frames, random gaps, occasional corrupted checksum
        for (int f = 0; f < 8; f++) begin
            int n;
            logic [7:0] bad;
            n = $urandom_range(1, 8);
            fr = {};
            for (int i = 0; i < 2 * n; i++) fr.push_back(8'($urandom_range(0, 255)));
            bad = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            pulse_start();
            send_frame(n, xor_of_frame() ^ bad, ($urandom_range(0, 1) == 1));
        end

        repeat (3) @(posedge clk);
        #1;
        check("final_pending", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
